net_tx_pkt_buf: RTL and testbench

//  Packet buffer feeding the W5500 socket transmit task. Accepts user bytes framed by a last flag,

---
 rtl/net_tx_pkt_buf_pkg.sv | 16 +
 rtl/net_tx_pkt_buf_len_fifo.sv | 47 ++++
 rtl/net_tx_pkt_buf.sv | 161 ++++++++++++++++
 tb/tb_net_tx_pkt_buf.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_tx_pkt_buf_pkg.sv
// Shared constants and read-sequencer state encoding
// for the socket transmit packet buffer.
package net_tx_pkt_buf_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int PKTQ_W_DEF  = 3;
  localparam int MAX_LEN_DEF = 1472;
  localparam int LEN_W       = 16;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_XFER = 2'd2
  } rd_state_e;

endpackage

// File: rtl/net_tx_pkt_buf_len_fifo.sv
// Packet length queue: synchronous FIFO with show-ahead
// head and occupancy count.
module net_tx_pkt_buf_len_fifo #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/net_tx_pkt_buf.sv
// Transmit packet buffer: stores whole user packets and
// replays the head packet until the sequencer consumes it.
module net_tx_pkt_buf
  import net_tx_pkt_buf_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int PKTQ_W  = PKTQ_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              usr_wr_en,
  input  logic [7:0]        usr_wr_dat,
  input  logic              usr_wr_last,
  output logic              usr_full,
  output logic              usr_drop,
  output logic              dat_tx_req,
  output logic [15:0]       txdat_len,
  output logic [7:0]        txdat,
  output logic              txdat_vld,
  input  logic              dat_rx_act,
  input  logic              dat_rx_rden,
  input  logic              tx_end,
  output logic [PKTQ_W:0]   pkt_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [7:0]        ram [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   wr_base;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   rd_ptr_nxt;
  logic [ADDR_W:0]   rd_base;
  logic [ADDR_W:0]   used;
  logic [15:0]       wr_len;
  logic [15:0]       rd_cnt;
  logic [15:0]       head;
  logic              discard;
  logic              q_full;
  logic              q_empty;
  logic              drop;
  logic              store;
  logic              push;
  logic              pop;
  logic              take;
  logic              done;
  logic              in_xfer;
  rd_state_e         state;
  rd_state_e         state_nxt;

  // rd_base only moves on release, so an unreleased
  // packet keeps its bytes reserved
  assign used     = wr_ptr - rd_base;
  assign usr_full = used[ADDR_W] | q_full;

  assign drop  = usr_wr_en && !discard &&
                 (usr_full || wr_len == 16'(MAX_LEN));
  assign store = usr_wr_en && !discard && !drop;
  assign push  = store && usr_wr_last;

  always_ff @(posedge clk) begin
    if (store) ram[wr_ptr[ADDR_W-1:0]] <= usr_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_base  <= '0;
      wr_len   <= '0;
      discard  <= 1'b0;
      usr_drop <= 1'b0;
    end else begin
      usr_drop <= drop;
      if (drop) begin
        wr_ptr  <= wr_base;
        wr_len  <= '0;
        discard <= !usr_wr_last;
      end else if (usr_wr_en && discard) begin
        if (usr_wr_last) discard <= 1'b0;
      end else if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (usr_wr_last) begin
          wr_base <= wr_ptr + 1'b1;
          wr_len  <= '0;
        end else begin
          wr_len <= wr_len + 16'd1;
        end
      end
    end
  end

  net_tx_pkt_buf_len_fifo #(
    .W  (LEN_W),
    .AW (PKTQ_W)
  ) u_len_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_len + 16'd1),
    .pop   (pop),
    .head  (head),
    .count (pkt_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  assign txdat_len = q_empty ? 16'd0 : head;
  assign in_xfer   = (state == R_XFER);
  assign done      = (rd_cnt == txdat_len);
  assign take      = in_xfer && dat_rx_rden &&
                     !tx_end && !done;
  assign pop       = in_xfer && tx_end && done;
  assign txdat_vld = in_xfer && (rd_cnt < txdat_len);

  always_comb begin
    state_nxt  = state;
    dat_tx_req = 1'b0;
    rd_ptr_nxt = rd_ptr;
    unique case (state)
      R_IDLE: begin
        if (pkt_cnt != '0) state_nxt = R_REQ;
      end
      R_REQ: begin
        dat_tx_req = 1'b1;
        if (dat_rx_act) state_nxt = R_XFER;
      end
      R_XFER: begin
        dat_tx_req = 1'b1;
        if (tx_end) state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
    if (take) begin
      rd_ptr_nxt = rd_ptr + 1'b1;
    end else if (in_xfer && tx_end && !done) begin
      rd_ptr_nxt = rd_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      rd_ptr  <= '0;
      rd_base <= '0;
      rd_cnt  <= '0;
      txdat   <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      txdat  <= ram[rd_ptr_nxt[ADDR_W-1:0]];
      if (pop) rd_base <= rd_ptr;
      if (in_xfer && tx_end) begin
        rd_cnt <= '0;
      end else if (take) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_net_tx_pkt_buf.sv
// Self-checking bench for net_tx_pkt_buf: packet-level
// reference model compared every cycle plus literal checks.
module tb_net_tx_pkt_buf;

  localparam int DEPTH   = 2048;
  localparam int QD      = 8;
  localparam int MAX_LEN = 1472;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        usr_wr_en = 1'b0;
  logic [7:0]  usr_wr_dat = '0;
  logic        usr_wr_last = 1'b0;
  logic        usr_full;
  logic        usr_drop;
  logic        dat_tx_req;
  logic [15:0] txdat_len;
  logic [7:0]  txdat;
  logic        txdat_vld;
  logic        dat_rx_act = 1'b0;
  logic        dat_rx_rden = 1'b0;
  logic        tx_end = 1'b0;
  logic [3:0]  pkt_cnt;

  net_tx_pkt_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .usr_wr_en   (usr_wr_en),
    .usr_wr_dat  (usr_wr_dat),
    .usr_wr_last (usr_wr_last),
    .usr_full    (usr_full),
    .usr_drop    (usr_drop),
    .dat_tx_req  (dat_tx_req),
    .txdat_len   (txdat_len),
    .txdat       (txdat),
    .txdat_vld   (txdat_vld),
    .dat_rx_act  (dat_rx_act),
    .dat_rx_rden (dat_rx_rden),
    .tx_end      (tx_end),
    .pkt_cnt     (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int drops_seen = 0;
  bit run = 1'b0;

  // packet-level model: committed bytes in order, their
  // lengths, the packet being assembled, and the phase
  logic [7:0] mem_q[$];
  int         len_q[$];
  logic [7:0] cur_q[$];
  bit         discard = 1'b0;
  bit         exp_drop = 1'b0;
  int         phase = 0;
  int         cons = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    len_q.delete();
    cur_q.delete();
    discard  = 1'b0;
    exp_drop = 1'b0;
    phase    = 0;
    cons     = 0;
  endtask

  task automatic model_edge(input logic en, input logic [7:0] d,
                            input logic last, input logic act,
                            input logic rden, input logic tend);
    int  hl;
    bit  full_o;
    full_o = (mem_q.size() + cur_q.size() == DEPTH) ||
             (len_q.size() == QD);
    exp_drop = 1'b0;
    case (phase)
      0: if (len_q.size() != 0) phase = 1;
      1: if (act) phase = 2;
      default: begin
        hl = len_q[0];
        if (tend) begin
          if (cons == hl) begin
            repeat (hl) void'(mem_q.pop_front());
            void'(len_q.pop_front());
          end
          cons  = 0;
          phase = 0;
        end else if (rden && cons < hl) begin
          cons++;
        end
      end
    endcase
    if (en) begin
      if (discard) begin
        if (last) discard = 1'b0;
      end else if (full_o || cur_q.size() == MAX_LEN) begin
        exp_drop = 1'b1;
        cur_q.delete();
        discard = !last;
      end else begin
        cur_q.push_back(d);
        if (last) begin
          foreach (cur_q[k]) mem_q.push_back(cur_q[k]);
          len_q.push_back(cur_q.size());
          cur_q.delete();
        end
      end
    end
  endtask

  always @(negedge clk) begin
    int  el;
    bit  ev;
    if (rst_n && run) begin
      el = (len_q.size() != 0) ? len_q[0] : 0;
      ev = (phase == 2) && (cons < el);
      chk("pkt_cnt", 32'(pkt_cnt), 32'(len_q.size()));
      chk("txdat_len", 32'(txdat_len), 32'(el));
      chk("usr_full", 32'(usr_full),
          32'((mem_q.size() + cur_q.size() == DEPTH) ||
              (len_q.size() == QD)));
      chk("usr_drop", 32'(usr_drop), 32'(exp_drop));
      chk("dat_tx_req", 32'(dat_tx_req), 32'(phase != 0));
      chk("txdat_vld", 32'(txdat_vld), 32'(ev));
      if (ev) chk("txdat", 32'(txdat), 32'(mem_q[cons]));
      if (usr_drop) drops_seen++;
    end
  end

  task automatic step(input logic en, input logic [7:0] d,
                      input logic last, input logic act,
                      input logic rden, input logic tend);
    usr_wr_en   = en;
    usr_wr_dat  = d;
    usr_wr_last = last;
    dat_rx_act  = act;
    dat_rx_rden = rden;
    tx_end      = tend;
    @(posedge clk);
    model_edge(en, d, last, act, rden, tend);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_pkt(input int n, input int base,
                           input bit with_last);
    for (int k = 0; k < n; k++)
      step(1'b1, 8'(base + k), with_last && (k == n - 1),
           1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !dat_tx_req; i++) idle();
    chk("req_wait", 32'(dat_tx_req), 32'd1);
  endtask

  task automatic drain(input int nrd, output logic [7:0] first);
    wait_req();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    first = txdat;
    for (int k = 0; k < nrd; k++)
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    logic [7:0] f;
    int d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_len", 32'(txdat_len), 32'd0);
    chk("rst_req", 32'(dat_tx_req), 32'd0);
    chk("rst_txdat", 32'(txdat), 32'd0);
    chk("rst_full", 32'(usr_full), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    idle();

    write_pkt(10, 0, 1'b1);
    idle();
    chk("req_after_last", 32'(dat_tx_req), 32'd1);
    chk("len_10", 32'(txdat_len), 32'd10);
    chk("txdat_show", 32'(txdat), 32'd0);

    drain(4, f);
    chk("first_try", 32'(f), 32'd0);
    chk("rewind_len", 32'(txdat_len), 32'd10);
    chk("rewind_cnt", 32'(pkt_cnt), 32'd1);
    drain(10, f);
    chk("retry_first", 32'(f), 32'd0);
    chk("release_cnt", 32'(pkt_cnt), 32'd0);
    chk("release_req", 32'(dat_tx_req), 32'd0);

    d0 = drops_seen;
    write_pkt(1473, 0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("oversize_drop", 32'(drops_seen - d0), 32'd1);
    chk("oversize_cnt", 32'(pkt_cnt), 32'd0);
    write_pkt(5, 8'hA0, 1'b1);
    idle();
    chk("after_drop_len", 32'(txdat_len), 32'd5);
    drain(5, f);
    chk("after_drop_first", 32'(f), 32'hA0);

    for (int i = 0; i < 8; i++) write_pkt(3, 16 * i, 1'b1);
    idle();
    chk("q_full", 32'(usr_full), 32'd1);
    d0 = drops_seen;
    write_pkt(3, 8'hEE, 1'b1);
    idle();
    chk("ninth_drop", 32'(drops_seen - d0), 32'd1);
    chk("ninth_cnt", 32'(pkt_cnt), 32'd8);
    drain(3, f);
    chk("unfull", 32'(usr_full), 32'd0);
    chk("unfull_cnt", 32'(pkt_cnt), 32'd7);
    for (int i = 1; i < 8; i++) drain(3, f);

    for (int i = 0; i < 4; i++) begin
      write_pkt(700, 37 * i, 1'b1);
      drain(700, f);
      chk("wrap_first", 32'(f), 32'(8'(37 * i)));
    end
    chk("wrap_cnt", 32'(pkt_cnt), 32'd0);

    write_pkt(6, 8'h50, 1'b1);
    wait_req();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    dat_rx_rden = 1'b0;
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("mid_rst_len", 32'(txdat_len), 32'd0);
    chk("mid_rst_req", 32'(dat_tx_req), 32'd0);
    chk("mid_rst_txdat", 32'(txdat), 32'd0);
    chk("mid_rst_vld", 32'(txdat_vld), 32'd0);
    chk("mid_rst_drop", 32'(usr_drop), 32'd0);
    chk("mid_rst_full", 32'(usr_full), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run   = 1'b1;
    write_pkt(4, 8'h60, 1'b1);
    drain(4, f);
    chk("post_rst_first", 32'(f), 32'h60);
    chk("post_rst_cnt", 32'(pkt_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
